// File: rtl/histeq_div_sequencer.sv
// Walks every histogram bin through CDF RAM -> divider -> LUT RAM, one bin per cycle.
// Optional output clamp to MAX_GRAY is compiled in with `define LUT_CLAMP_EN.
module histeq_div_sequencer #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int NUM_BINS = 256,
  parameter int RAM_LAT  = 1,
  parameter int DIV_LAT  = 1
`ifdef LUT_CLAMP_EN
  , parameter int MAX_GRAY = 255
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
`ifdef LUT_CLAMP_EN
  input  logic              clamp_en,
`endif
  output logic              busy,
  output logic              done,
  output logic              cdf_rd_en,
  output logic [ADDR_W-1:0] cdf_addr,
  input  logic [DATA_W-1:0] cdf_rdata,
  output logic [DATA_W-1:0] div_cdf_in,
  input  logic [DATA_W-1:0] div_g_out,
  output logic              lut_we,
  output logic [ADDR_W-1:0] lut_addr,
  output logic [DATA_W-1:0] lut_wdata,
  output logic [1:0]        state_dbg
);

  // No backpressure anywhere: cdf_rd_en and lut_we are one-cycle strobes that the
  // RAMs must accept unconditionally; RAM_LAT and DIV_LAT must both be at least 1.
  localparam int PIPE_D = RAM_LAT + 1 + DIV_LAT;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BINS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] rd_addr, rd_addr_nxt;
  logic              issue;
  logic              flush;
  logic [PIPE_D-1:0] vld;
  logic [ADDR_W-1:0] addr_pipe [PIPE_D];
  logic [DATA_W-1:0] wr_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      rd_addr <= '0;
    end else begin
      state   <= state_nxt;
      rd_addr <= rd_addr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rd_addr_nxt = rd_addr;
    flush       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = ISSUE;
          rd_addr_nxt = '0;
        end
      end
      ISSUE: begin
        rd_addr_nxt = rd_addr + ADDR_W'(1);
        if (rd_addr == LAST_ADDR) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (lut_we && (lut_addr == LAST_ADDR)) state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Abort overrides every transition, including the DRAIN->FIN one, so done never fires.
    if (abort && (state != IDLE)) begin
      state_nxt = IDLE;
      flush     = 1'b1;
    end
  end

  assign issue     = (state == ISSUE);
  assign cdf_rd_en = issue;
  assign cdf_addr  = issue ? rd_addr : '0;
  assign busy      = issue || (state == DRAIN);
  assign done      = (state == FIN);
  assign state_dbg = state;

`ifdef LUT_CLAMP_EN
  localparam logic [DATA_W-1:0] MAX_G = DATA_W'(MAX_GRAY);
  assign wr_data = (clamp_en && (div_g_out > MAX_G)) ? MAX_G : div_g_out;
`else
  assign wr_data = div_g_out;
`endif

  // vld[i] high means the bin in addr_pipe[i] was issued i+1 edges ago.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld        <= '0;
      div_cdf_in <= '0;
      lut_we     <= 1'b0;
      lut_addr   <= '0;
      lut_wdata  <= '0;
      for (int i = 0; i < PIPE_D; i++) addr_pipe[i] <= '0;
    end else begin
      vld          <= flush ? '0 : {vld[PIPE_D-2:0], issue};
      addr_pipe[0] <= cdf_addr;
      for (int i = 1; i < PIPE_D; i++) addr_pipe[i] <= addr_pipe[i-1];
      if (vld[RAM_LAT-1]) div_cdf_in <= cdf_rdata;
      lut_we <= vld[PIPE_D-1] && !flush;
      if (vld[PIPE_D-1]) begin
        lut_addr  <= addr_pipe[PIPE_D-1];
        lut_wdata <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_histeq_div_sequencer.sv
// Bench for histeq_div_sequencer: a default-latency instance driven from a scenario table
// and a RAM_LAT=2 / DIV_LAT=3 instance for the latency sweep.
module tb_histeq_div_sequencer;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int NB = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- DUT A (default latencies) ----------------
  logic          start_a, abort_a, busy_a, done_a, cdf_rd_en_a, lut_we_a;
  logic [AW-1:0] cdf_addr_a, lut_addr_a;
  logic [DW-1:0] cdf_rdata_a, div_cdf_in_a, div_g_out_a, lut_wdata_a;
  logic [1:0]    state_a;

  histeq_div_sequencer u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
    .busy(busy_a), .done(done_a), .cdf_rd_en(cdf_rd_en_a), .cdf_addr(cdf_addr_a),
    .cdf_rdata(cdf_rdata_a), .div_cdf_in(div_cdf_in_a), .div_g_out(div_g_out_a),
    .lut_we(lut_we_a), .lut_addr(lut_addr_a), .lut_wdata(lut_wdata_a),
    .state_dbg(state_a)
  );

  logic [DW-1:0] mem_a [NB];
  always @(posedge clk) cdf_rdata_a <= mem_a[cdf_addr_a];
  always @(posedge clk) div_g_out_a <= 8'(32'(div_cdf_in_a) * 2);

  // ---------------- DUT B (RAM_LAT=2, DIV_LAT=3) ----------------
  logic          start_b, abort_b, busy_b, done_b, cdf_rd_en_b, lut_we_b;
  logic [AW-1:0] cdf_addr_b, lut_addr_b;
  logic [DW-1:0] cdf_rdata_b, div_cdf_in_b, div_g_out_b, lut_wdata_b;
  logic [1:0]    state_b;

  histeq_div_sequencer #(.RAM_LAT(2), .DIV_LAT(3)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .cdf_rd_en(cdf_rd_en_b), .cdf_addr(cdf_addr_b),
    .cdf_rdata(cdf_rdata_b), .div_cdf_in(div_cdf_in_b), .div_g_out(div_g_out_b),
    .lut_we(lut_we_b), .lut_addr(lut_addr_b), .lut_wdata(lut_wdata_b),
    .state_dbg(state_b)
  );

  logic [DW-1:0] mem_b [NB];
  logic [DW-1:0] ram_b_p0;
  logic [DW-1:0] div_b_p [3];
  always @(posedge clk) begin
    ram_b_p0    <= mem_b[cdf_addr_b];
    cdf_rdata_b <= ram_b_p0;
  end
  always @(posedge clk) begin
    div_b_p[0] <= div_cdf_in_b ^ 8'h5A;
    div_b_p[1] <= div_b_p[0];
    div_b_p[2] <= div_b_p[1];
  end
  assign div_g_out_b = div_b_p[2];

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboards ----------------
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] exp_qb[$];
  int first_rd_a, first_wr_a, last_wr_a, wr_cnt_a, done_cnt_a, done_cyc_a;
  int first_rd_b, first_wr_b, last_wr_b, wr_cnt_b, done_cnt_b, done_cyc_b;

  always @(negedge clk) begin
    if (cdf_rd_en_a && first_rd_a < 0) first_rd_a = cyc;
    if (lut_we_a) begin
      wr_cnt_a++;
      if (first_wr_a < 0) first_wr_a = cyc;
      last_wr_a = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL a_lut_write: unexpected write addr=%0d data=0x%0h", lut_addr_a, lut_wdata_a);
      end else begin
        check("a_lut_write", 32'({lut_addr_a, lut_wdata_a}), 32'(exp_q.pop_front()));
      end
    end
    if (done_a) begin
      done_cnt_a++;
      done_cyc_a = cyc;
      check("a_busy_at_done", 32'(busy_a), 32'(0));
    end
  end

  always @(negedge clk) begin
    if (cdf_rd_en_b && first_rd_b < 0) first_rd_b = cyc;
    if (lut_we_b) begin
      wr_cnt_b++;
      if (first_wr_b < 0) first_wr_b = cyc;
      last_wr_b = cyc;
      if (exp_qb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL b_lut_write: unexpected write addr=%0d data=0x%0h", lut_addr_b, lut_wdata_b);
      end else begin
        check("b_lut_write", 32'({lut_addr_b, lut_wdata_b}), 32'(exp_qb.pop_front()));
      end
    end
    if (done_b) begin
      done_cnt_b++;
      done_cyc_b = cyc;
      check("b_busy_at_done", 32'(busy_b), 32'(0));
    end
  end

  // ---------------- driver tasks ----------------
  typedef struct {
    string name;
    int    mul;
    int    add;
    int    abort_bin;
    int    extra1;
    int    extra2;
    bit    start_abort;
    bit    start_at_done;
    int    exp_writes;
    int    exp_done;
  } scen_t;

  task automatic clear_a();
    first_rd_a = -1; first_wr_a = -1; last_wr_a = -1;
    wr_cnt_a = 0; done_cnt_a = 0; done_cyc_a = -1;
    exp_q.delete();
  endtask

  task automatic pulse_start_a(input logic with_abort);
    @(posedge clk); #1;
    start_a = 1'b1;
    abort_a = with_abort;
    @(posedge clk); #1;
    start_a = 1'b0;
    abort_a = 1'b0;
  endtask

  task automatic run_scenario(input scen_t s);
    bit finished = 0;
    bit aborted = 0;
    int post = 0;
    logic [DW-1:0] d;
    clear_a();
    for (int k = 0; k < NB; k++) mem_a[k] = 8'(k * s.mul + s.add);
    for (int k = 0; k < s.exp_writes; k++) begin
      d = 8'(32'(mem_a[k]) * 2);
      exp_q.push_back({8'(k), d});
    end
    pulse_start_a(s.start_abort);
    check({s.name, "/busy_after_start"}, 32'(busy_a), 32'(1));
    for (int c = 0; c < 1500 && !finished; c++) begin
      @(negedge clk); #1;
      if (s.abort_bin >= 0 && !aborted && cdf_rd_en_a && int'(cdf_addr_a) == s.abort_bin) begin
        abort_a = 1'b1;
        @(posedge clk); #1;
        abort_a = 1'b0;
        aborted = 1;
        check({s.name, "/busy_after_abort"}, 32'(busy_a), 32'(0));
        check({s.name, "/rd_en_after_abort"}, 32'(cdf_rd_en_a), 32'(0));
      end
      if (cdf_rd_en_a && (int'(cdf_addr_a) == s.extra1 || int'(cdf_addr_a) == s.extra2)) begin
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
      end
      if (done_a) begin
        if (s.start_at_done) begin
          start_a = 1'b1;
          @(posedge clk); #1;
          start_a = 1'b0;
          check({s.name, "/start_at_done_busy"}, 32'(busy_a), 32'(0));
          check({s.name, "/start_at_done_state"}, 32'(state_a), 32'(0));
        end
        finished = 1;
      end
      if (aborted) begin
        post++;
        if (post >= 20) finished = 1;
      end
    end
    if (!finished) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s/timeout: run did not complete within 1500 cycles", s.name);
    end
    repeat (5) @(posedge clk);
    #1;
    check({s.name, "/writes"}, 32'(wr_cnt_a), 32'(s.exp_writes));
    check({s.name, "/dones"}, 32'(done_cnt_a), 32'(s.exp_done));
    check({s.name, "/queue_left"}, 32'(exp_q.size()), 32'(0));
    if (wr_cnt_a > 0) begin
      check({s.name, "/first_write_latency"}, 32'(first_wr_a - first_rd_a), 32'(4));
      check({s.name, "/consecutive"}, 32'(last_wr_a - first_wr_a + 1), 32'(wr_cnt_a));
    end
    if (s.exp_done > 0) check({s.name, "/done_after_last"}, 32'(done_cyc_a), 32'(last_wr_a + 1));
    check({s.name, "/idle_after"}, 32'({busy_a, cdf_rd_en_a, state_a}), 32'(0));
  endtask

  // ---------------- main sequence ----------------
  scen_t scen [8];
  bit    found;

  initial begin
    reset = 1'b0;
    start_a = 1'b0; abort_a = 1'b0;
    start_b = 1'b0; abort_b = 1'b0;
    clear_a();
    first_rd_b = -1; first_wr_b = -1; last_wr_b = -1;
    wr_cnt_b = 0; done_cnt_b = 0; done_cyc_b = -1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy_a), 32'(0));
    check("rst_done", 32'(done_a), 32'(0));
    check("rst_rd_en", 32'(cdf_rd_en_a), 32'(0));
    check("rst_lut_we", 32'(lut_we_a), 32'(0));
    check("rst_cdf_addr", 32'(cdf_addr_a), 32'(0));
    check("rst_lut_addr", 32'(lut_addr_a), 32'(0));
    check("rst_lut_wdata", 32'(lut_wdata_a), 32'(0));
    check("rst_div_in", 32'(div_cdf_in_a), 32'(0));
    check("rst_state", 32'(state_a), 32'(0));
    reset = 1'b1;

    //          name            mul add abort ext1 ext2 s+a s@d writes done
    scen[0] = '{"full_ramp",      1,  0,  -1,  -1,  -1, 0,  0,  256,  1};
    scen[1] = '{"abort_100",      1,  0, 100,  -1,  -1, 0,  0,   97,  0};
    scen[2] = '{"rebuild",        3,  7,  -1,  -1,  -1, 0,  0,  256,  1};
    scen[3] = '{"start_ignored",  1,  0,  -1,  10, 200, 0,  0,  256,  1};
    scen[4] = '{"abort_early",    5, 200,   3,  -1,  -1, 0,  0,    0,  0};
    scen[5] = '{"abort_last",     1,  0, 255,  -1,  -1, 0,  0,  252,  0};
    scen[6] = '{"start_at_done",  7, 13,  -1,  -1,  -1, 0,  1,  256,  1};
    scen[7] = '{"start_w_abort",  2,  1,  -1,  -1,  -1, 1,  0,  256,  1};

    for (int i = 0; i < 8; i++) begin
      run_scenario(scen[i]);
      repeat (3) @(posedge clk);
    end

    // Reset asserted mid-run while bin 40 is being read.
    clear_a();
    for (int k = 0; k < NB; k++) mem_a[k] = 8'(k);
    for (int k = 0; k < 37; k++) exp_q.push_back({8'(k), 8'(2 * k)});
    pulse_start_a(1'b0);
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk); #1;
      if (cdf_rd_en_a && cdf_addr_a == 8'd40) found = 1;
    end
    check("mid_reset/reached_bin40", 32'(found), 32'(1));
    #2 reset = 1'b0;
    #1;
    check("mid_reset/busy", 32'(busy_a), 32'(0));
    check("mid_reset/rd_en", 32'(cdf_rd_en_a), 32'(0));
    check("mid_reset/cdf_addr", 32'(cdf_addr_a), 32'(0));
    check("mid_reset/lut_we", 32'(lut_we_a), 32'(0));
    check("mid_reset/lut_addr", 32'(lut_addr_a), 32'(0));
    check("mid_reset/lut_wdata", 32'(lut_wdata_a), 32'(0));
    check("mid_reset/div_in", 32'(div_cdf_in_a), 32'(0));
    check("mid_reset/done", 32'(done_a), 32'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    check("mid_reset/writes", 32'(wr_cnt_a), 32'(37));
    check("mid_reset/dones", 32'(done_cnt_a), 32'(0));
    check("mid_reset/queue_left", 32'(exp_q.size()), 32'(0));
    check("mid_reset/idle", 32'({busy_a, state_a}), 32'(0));

    // Latency sweep on the RAM_LAT=2 / DIV_LAT=3 instance.
    first_rd_b = -1; first_wr_b = -1; last_wr_b = -1;
    wr_cnt_b = 0; done_cnt_b = 0; done_cyc_b = -1;
    exp_qb.delete();
    for (int k = 0; k < NB; k++) begin
      mem_b[k] = 8'(255 - k);
      exp_qb.push_back({8'(k), 8'(255 - k) ^ 8'h5A});
    end
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    check("lat/busy_after_start", 32'(busy_b), 32'(1));
    found = 0;
    for (int c = 0; c < 1000 && !found; c++) begin
      @(negedge clk); #1;
      if (done_cnt_b > 0) found = 1;
    end
    check("lat/done_seen", 32'(found), 32'(1));
    repeat (5) @(posedge clk);
    #1;
    check("lat/writes", 32'(wr_cnt_b), 32'(256));
    check("lat/dones", 32'(done_cnt_b), 32'(1));
    check("lat/queue_left", 32'(exp_qb.size()), 32'(0));
    check("lat/first_write_latency", 32'(first_wr_b - first_rd_b), 32'(7));
    check("lat/consecutive", 32'(last_wr_b - first_wr_b + 1), 32'(256));
    check("lat/done_after_last", 32'(done_cyc_b), 32'(last_wr_b + 1));
    check("lat/idle_after", 32'({busy_b, cdf_rd_en_b, state_b}), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
